// File: rtl/mem_inst_pkg.sv
// Shared encodings for the memory-instruction sequencer: opcodes, FSM
// states and instruction field positions.
package mem_inst_pkg;

  localparam int OP_LSB   = 4;
  localparam int OP_MSB   = 6;
  localparam int NIB_LSB  = 0;
  localparam int NIB_MSB  = 3;
  localparam int LANE_LSB = 7;

  typedef enum logic [2:0] {
    OP_READ  = 3'b000,
    OP_SHIFT = 3'b101,
    OP_WFI   = 3'b110,
    OP_LOOP  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_SH_WAIT  = 3'd4,
    S_WFI_WAIT = 3'd5
  } state_e;

  // Only four of the eight opcode values do anything.
  function automatic logic op_legal(logic [2:0] op);
    return (op == OP_READ) || (op == OP_SHIFT) || (op == OP_WFI) || (op == OP_LOOP);
  endfunction

endpackage

// File: rtl/mem_inst_decode.sv
// Combinational field extraction for one instruction word.
module mem_inst_decode
  import mem_inst_pkg::*;
#(
  parameter int INST_WIDTH = 56
) (
  input  logic [INST_WIDTH-1:0]          inst,
  output logic [2:0]                     opcode,
  output logic [3:0]                     nib,
  output logic [INST_WIDTH-LANE_LSB-1:0] lanes,
  output logic                           illegal
);

  assign opcode  = inst[OP_MSB:OP_LSB];
  assign nib     = inst[NIB_MSB:NIB_LSB];
  assign lanes   = inst[INST_WIDTH-1:LANE_LSB];
  assign illegal = !op_legal(opcode);

endmodule

// File: rtl/mem_inst_sequencer.sv
// Memory-instruction sequencer: fetches words from a registered ROM and
// issues read / shift / wait-for-compute commands, looping the program
// NUM_ITER times. One external command is outstanding at any time.
module mem_inst_sequencer
  import mem_inst_pkg::*;
#(
  parameter int INST_WIDTH = 56,
  parameter int ADDR_WIDTH = 4,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [ITER_WIDTH-1:0] NUM_ITER,
  output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
  output logic                  ROM_ENABLE,
  input  logic [INST_WIDTH-1:0] ROM_DATA,
  output logic                  RD_REQ,
  output logic [3:0]            RD_MASK,
  input  logic                  RD_ACK,
  output logic                  SHIFT_VALID,
  output logic [3:0]            SHIFT_AMT,
  output logic [INST_WIDTH-8:0] SHIFT_LANES,
  input  logic                  SHIFT_READY,
  input  logic                  COMPUTE_DONE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [ITER_WIDTH-1:0] ITER_COUNT
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [ITER_WIDTH-1:0] num_iter_q, num_iter_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [INST_WIDTH-1:0] cur_inst;
  logic [2:0]            dec_op;
  logic [3:0]            dec_nib;
  logic [INST_WIDTH-8:0] dec_lanes;
  logic                  dec_illegal;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ITER_WIDTH-1:0] iter_inc;
  logic                  rom_en, rd_req, sh_vld;

  // In EXEC the word is still on ROM_DATA; afterwards it lives in inst_q,
  // so command fields stay stable for the whole handshake.
  assign cur_inst = (state_q == S_EXEC) ? ROM_DATA : inst_q;

  mem_inst_decode #(.INST_WIDTH(INST_WIDTH)) u_dec (
    .inst    (cur_inst),
    .opcode  (dec_op),
    .nib     (dec_nib),
    .lanes   (dec_lanes),
    .illegal (dec_illegal)
  );

  assign pc_inc   = pc_q + ADDR_WIDTH'(1);
  assign iter_inc = iter_q + ITER_WIDTH'(1);

  assign ROM_ADDRESS = pc_q;
  assign ROM_ENABLE  = rom_en;
  assign RD_REQ      = rd_req;
  assign RD_MASK     = dec_nib;
  assign SHIFT_VALID = sh_vld;
  assign SHIFT_AMT   = dec_nib;
  assign SHIFT_LANES = dec_lanes;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERROR       = error_q;
  assign ITER_COUNT  = iter_q;

  // Next-state, PC/counter updates and command strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iter_d     = iter_q;
    num_iter_d = num_iter_q;
    inst_d     = inst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    rom_en     = 1'b0;
    rd_req     = 1'b0;
    sh_vld     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          num_iter_d = (NUM_ITER == '0) ? ITER_WIDTH'(1) : NUM_ITER;
          pc_d       = '0;
          iter_d     = '0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        rom_en  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        inst_d = ROM_DATA;
        if (dec_illegal) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          case (dec_op)
            OP_READ: begin
              rd_req = 1'b1;
              if (RD_ACK) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
              end else begin
                state_d = S_RD_WAIT;
              end
            end
            OP_SHIFT: begin
              sh_vld = 1'b1;
              if (SHIFT_READY) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
              end else begin
                state_d = S_SH_WAIT;
              end
            end
            OP_WFI: begin
              if (COMPUTE_DONE) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
              end else begin
                state_d = S_WFI_WAIT;
              end
            end
            OP_LOOP: begin
              iter_d = iter_inc;
              if (iter_inc == num_iter_q) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end else begin
                pc_d    = '0;
                state_d = S_FETCH;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RD_WAIT: begin
        rd_req = 1'b1;
        if (RD_ACK) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_SH_WAIT: begin
        sh_vld = 1'b1;
        if (SHIFT_READY) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_WFI_WAIT: begin
        if (COMPUTE_DONE) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; synchronous reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      iter_q     <= '0;
      num_iter_q <= ITER_WIDTH'(1);
      inst_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iter_q     <= iter_d;
      num_iter_q <= num_iter_d;
      inst_q     <= inst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_mem_inst_sequencer.sv
// Scoreboard bench for mem_inst_sequencer: expected fetches, commands and
// DONE events are queued when a run is launched and consumed by a monitor.
module tb_mem_inst_sequencer;
  localparam int IW = 56;
  localparam int AW = 4;
  localparam int NW = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic [NW-1:0] NUM_ITER = '0;
  logic [AW-1:0] ROM_ADDRESS;
  logic          ROM_ENABLE;
  logic [IW-1:0] ROM_DATA = '0;
  logic          RD_REQ;
  logic [3:0]    RD_MASK;
  logic          RD_ACK;
  logic          SHIFT_VALID;
  logic [3:0]    SHIFT_AMT;
  logic [IW-8:0] SHIFT_LANES;
  logic          SHIFT_READY;
  logic          COMPUTE_DONE;
  logic          BUSY, DONE, ERROR;
  logic [NW-1:0] ITER_COUNT;

  mem_inst_sequencer #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .ITER_WIDTH(NW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .NUM_ITER(NUM_ITER),
    .ROM_ADDRESS(ROM_ADDRESS), .ROM_ENABLE(ROM_ENABLE), .ROM_DATA(ROM_DATA),
    .RD_REQ(RD_REQ), .RD_MASK(RD_MASK), .RD_ACK(RD_ACK),
    .SHIFT_VALID(SHIFT_VALID), .SHIFT_AMT(SHIFT_AMT), .SHIFT_LANES(SHIFT_LANES),
    .SHIFT_READY(SHIFT_READY), .COMPUTE_DONE(COMPUTE_DONE),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ITER_COUNT(ITER_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [IW-8:0] ln,
                                       input logic [3:0] nib);
    return {ln, op, nib};
  endfunction

  localparam logic [IW-8:0] LANES = 49'h1_2345_6789_ABCD;

  // Registered ROM model.
  logic [IW-1:0] rom [16];
  always @(posedge CLK) if (ROM_ENABLE) ROM_DATA <= rom[ROM_ADDRESS];

  // Responders with programmable latency.
  int rd_delay = 0, sh_delay = 0, wfi_delay = 0;
  int rd_cnt = 0, sh_cnt = 0, wfi_cnt = 0;
  logic fetch_wfi = 1'b0, wfi_hold = 1'b0;
  logic wfi_active;
  assign RD_ACK       = RD_REQ && (rd_cnt >= rd_delay);
  assign SHIFT_READY  = SHIFT_VALID && (sh_cnt >= sh_delay);
  assign wfi_active   = fetch_wfi || wfi_hold;
  assign COMPUTE_DONE = wfi_active && (wfi_cnt >= wfi_delay);

  always @(posedge CLK) begin
    rd_cnt    <= (RD_REQ && !RD_ACK && !RESET) ? rd_cnt + 1 : 0;
    sh_cnt    <= (SHIFT_VALID && !SHIFT_READY && !RESET) ? sh_cnt + 1 : 0;
    fetch_wfi <= ROM_ENABLE && (rom[ROM_ADDRESS][6:4] == 3'b110) && !RESET;
    wfi_hold  <= wfi_active && !COMPUTE_DONE && !RESET;
    wfi_cnt   <= (wfi_active && !COMPUTE_DONE && !RESET) ? wfi_cnt + 1 : 0;
  end

  // Scoreboard queues.
  int            fetch_q[$];
  logic [3:0]    rd_q[$];
  logic [3:0]    sha_q[$];
  logic [IW-8:0] shl_q[$];
  int            done_q[$];
  int            rd_hi = 0, sh_hi = 0;

  // Monitor: compare DUT activity with the queued expectations.
  always @(negedge CLK) begin
    if (!RESET) begin
      chk("excl", (int'(ROM_ENABLE) + int'(RD_REQ) + int'(SHIFT_VALID)) <= 1, 1);
      if (ROM_ENABLE) begin
        chk("fetch_exp", fetch_q.size() > 0, 1);
        if (fetch_q.size() > 0) chk("fetch_addr", ROM_ADDRESS, fetch_q.pop_front());
      end
      if (RD_REQ) begin
        chk("rd_exp", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) begin
          chk("rd_mask", RD_MASK, rd_q[0]);
          if (RD_ACK) begin
            chk("rd_len", rd_hi + 1, rd_delay + 1);
            void'(rd_q.pop_front());
          end
        end
      end
      if (SHIFT_VALID) begin
        chk("sh_exp", sha_q.size() > 0, 1);
        if (sha_q.size() > 0) begin
          chk("sh_amt", SHIFT_AMT, sha_q[0]);
          chk("sh_lanes", SHIFT_LANES, shl_q[0]);
          if (SHIFT_READY) begin
            chk("sh_len", sh_hi + 1, sh_delay + 1);
            void'(sha_q.pop_front());
            void'(shl_q.pop_front());
          end
        end
      end
      if (wfi_active && !COMPUTE_DONE) begin
        chk("wfi_busy", BUSY, 1);
        chk("wfi_nofetch", ROM_ENABLE, 0);
      end
      if (DONE) begin
        chk("done_exp", done_q.size() > 0, 1);
        if (done_q.size() > 0) chk("done_iter", ITER_COUNT, done_q.pop_front());
        chk("done_early", fetch_q.size(), 0);
      end
    end
    rd_hi <= (RD_REQ && !RD_ACK && !RESET) ? rd_hi + 1 : 0;
    sh_hi <= (SHIFT_VALID && !SHIFT_READY && !RESET) ? sh_hi + 1 : 0;
  end

  task automatic load_prog();
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[0] = mk(3'b000, '0, 4'b0001);
    rom[1] = mk(3'b101, LANES, 4'hF);
    rom[2] = mk(3'b110, '0, 4'h0);
    rom[3] = mk(3'b111, '0, 4'h0);
  endtask

  task automatic push_prog(input int passes);
    for (int p = 0; p < passes; p++) begin
      for (int a = 0; a < 4; a++) fetch_q.push_back(a);
      rd_q.push_back(4'b0001);
      sha_q.push_back(4'hF);
      shl_q.push_back(LANES);
    end
    done_q.push_back(passes);
  endtask

  task automatic flush();
    fetch_q.delete(); rd_q.delete(); sha_q.delete(); shl_q.delete(); done_q.delete();
  endtask

  task automatic start_run(input int n);
    @(posedge CLK); #1;
    START = 1'b1; NUM_ITER = NW'(n);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    chk("run_timeout", k < 2000, 1);
    repeat (2) @(negedge CLK);
    chk("fetch_left", fetch_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
    chk("sh_left", sha_q.size(), 0);
    chk("done_left", done_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    flush();
  endtask

  initial begin
    load_prog();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_error", ERROR, 0);
    chk("rst_romen", ROM_ENABLE, 0);
    chk("rst_rdreq", RD_REQ, 0);
    chk("rst_shvld", SHIFT_VALID, 0);
    chk("rst_addr", ROM_ADDRESS, 0);
    chk("rst_iter", ITER_COUNT, 0);

    // Single pass, all responders immediate.
    push_prog(1);
    start_run(1);
    wait_idle();
    chk("iter_1", ITER_COUNT, 1);

    // Three passes with a stray START mid-run that must be ignored.
    push_prog(3);
    start_run(3);
    repeat (4) @(posedge CLK);
    #1 START = 1'b1; NUM_ITER = 16'd7;
    @(posedge CLK); #1 START = 1'b0;
    wait_idle();
    chk("iter_3", ITER_COUNT, 3);
    repeat (3) @(negedge CLK);
    chk("iter_hold", ITER_COUNT, 3);

    // NUM_ITER of zero runs a single pass.
    push_prog(1);
    start_run(0);
    wait_idle();
    chk("iter_zero", ITER_COUNT, 1);

    // Slow read ack, slow shifter, long compute wait.
    rd_delay = 5; sh_delay = 3; wfi_delay = 10;
    push_prog(2);
    start_run(2);
    wait_idle();
    chk("iter_slow", ITER_COUNT, 2);
    rd_delay = 0; sh_delay = 0; wfi_delay = 0;

    // Illegal opcode at address 2: error, no DONE.
    rom[2] = mk(3'b010, '0, 4'h0);
    for (int a = 0; a < 3; a++) fetch_q.push_back(a);
    rd_q.push_back(4'b0001);
    sha_q.push_back(4'hF);
    shl_q.push_back(LANES);
    start_run(1);
    wait_idle();
    chk("ill_error", ERROR, 1);
    chk("ill_busy", BUSY, 0);
    load_prog();
    push_prog(1);
    start_run(1);
    wait_idle();
    chk("err_sticky", ERROR, 1);
    do_reset();
    @(negedge CLK);
    chk("err_cleared", ERROR, 0);

    // Reset while a shift is waiting for the shifter.
    sh_delay = 50;
    push_prog(1);
    start_run(1);
    begin
      int k = 0;
      while (!SHIFT_VALID && k < 200) begin
        @(negedge CLK);
        k++;
      end
    end
    chk("sh_seen", SHIFT_VALID, 1);
    repeat (2) @(negedge CLK);
    chk("sh_hold", SHIFT_VALID, 1);
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rstsh_valid", SHIFT_VALID, 0);
    chk("rstsh_busy", BUSY, 0);
    chk("rstsh_pc", ROM_ADDRESS, 0);
    @(posedge CLK); #1 RESET = 1'b0;
    flush();
    sh_delay = 0;
    push_prog(1);
    start_run(1);
    wait_idle();
    chk("iter_restart", ITER_COUNT, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_inst_sequencer.md
MEM_INST_SEQUENCER -- requirements
Module: mem_inst_sequencer

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 56, memory-instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, instruction ROM address width.
REQ-003 SHALL have parameter ITER_WIDTH, default 16, iteration counter width.
REQ-004 SHALL have ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse; begin program run
NUM_ITER  in  ITER_WIDTH  number of program passes; sampled on accepted START
ROM_ADDRESS  out  ADDR_WIDTH  instruction fetch address
ROM_ENABLE  out  1  fetch strobe
ROM_DATA  in  INST_WIDTH  registered ROM word, valid the cycle after ROM_ENABLE
RD_REQ  out  1  memory read request, held until RD_ACK
RD_MASK  out  4  read-lane enables (instruction bits [3:0])
RD_ACK  in  1  read accepted
SHIFT_VALID  out  1  shift command valid
SHIFT_AMT  out  4  shift amount (instruction bits [3:0])
SHIFT_LANES  out  INST_WIDTH-7  lane-select field (instruction bits [INST_WIDTH-1:7])
SHIFT_READY  in  1  shifter accepts command
COMPUTE_DONE  in  1  PE array done; releases WFI
BUSY  out  1  program running
DONE  out  1  one-cycle pulse at end of final pass
ERROR  out  1  sticky illegal-opcode flag
ITER_COUNT  out  ITER_WIDTH  completed passes in current run

Function
REQ-005 Opcode SHALL be bits [6:4]: 000 READ, 101 SHIFT, 110 WFI, 111 LOOP; all others illegal.
REQ-006 States SHALL be IDLE, FETCH, EXEC, RD_WAIT, SH_WAIT, WFI_WAIT.
REQ-007 IDLE: on START, SHALL latch NUM_ITER (0 treated as 1), clear PC and ITER_COUNT, set BUSY, go FETCH; START outside IDLE ignored.
REQ-008 FETCH: SHALL assert ROM_ENABLE exactly one cycle with ROM_ADDRESS=PC, go EXEC.
REQ-009 EXEC: SHALL latch ROM_DATA into instruction register and dispatch on opcode the same cycle.
REQ-010 READ: RD_REQ SHALL assert from EXEC until the cycle RD_REQ&RD_ACK (RD_WAIT holds); RD_MASK stable while RD_REQ high; on handshake PC+1, go FETCH.
REQ-011 SHIFT: SHIFT_VALID SHALL assert from EXEC until SHIFT_VALID&SHIFT_READY (SH_WAIT holds); SHIFT_AMT/SHIFT_LANES stable while valid; on handshake PC+1, go FETCH.
REQ-012 Same-cycle ack (RD_ACK or SHIFT_READY high in EXEC) SHALL complete in EXEC; minimum 2 cycles per instruction.
REQ-013 WFI: SHALL wait in WFI_WAIT until COMPUTE_DONE high (COMPUTE_DONE high in EXEC completes immediately), then PC+1, FETCH.
REQ-014 LOOP: ITER_COUNT+1; if new ITER_COUNT equals latched NUM_ITER, pulse DONE, clear BUSY, go IDLE; else PC=0, go FETCH.
REQ-015 PC increment SHALL wrap modulo 2^ADDR_WIDTH.
REQ-016 Illegal opcode SHALL set ERROR (sticky until RESET), clear BUSY, go IDLE without DONE.
REQ-017 RD_REQ, SHIFT_VALID, ROM_ENABLE SHALL be mutually exclusive; at most one external command outstanding.
REQ-018 ITER_COUNT SHALL hold its final value in IDLE until next accepted START.

Reset
REQ-019 RESET SHALL have priority over all inputs, including mid-handshake, and force IDLE.
REQ-020 Reset values: PC=0, ITER_COUNT=0, ROM_ENABLE=0, RD_REQ=0, SHIFT_VALID=0, BUSY=0, DONE=0, ERROR=0, instruction register=0, ROM_ADDRESS=0.

Structure
REQ-021 Opcode encodings, state encoding and field bit positions SHALL live in shared package mem_inst_pkg.
REQ-022 Field extraction SHALL be a sub-module mem_inst_decode (combinational: instruction word -> opcode, low nibble, lane field, illegal flag).
REQ-023 No sub-module other than mem_inst_decode; FSM, PC and counters in mem_inst_sequencer.

Verification
REQ-024 ROM [READ mask 0001, SHIFT amt 15, WFI, LOOP], NUM_ITER=1, acks tied high -> ROM_ADDRESS 0,1,2,3; RD_MASK=0001; SHIFT_AMT=15; DONE pulse once; ITER_COUNT=1.
REQ-025 Same program, NUM_ITER=3 -> three passes, ROM_ADDRESS returns to 0 after each LOOP, DONE only after third LOOP, ITER_COUNT=3.
REQ-026 RD_ACK delayed 5 cycles -> RD_REQ high 6 cycles, RD_MASK stable, no fetch until handshake.
REQ-027 COMPUTE_DONE low 10 cycles in WFI -> BUSY stays 1, no ROM_ENABLE until COMPUTE_DONE, then fetch of PC+1.
REQ-028 Opcode 010 at address 2 -> ERROR=1, BUSY=0, no DONE; new START runs program, ERROR stays 1 until RESET.
REQ-029 RESET during SH_WAIT -> next cycle SHIFT_VALID=0, BUSY=0, PC=0; START restarts from address 0.
